// File: rtl/lvds_pkg.sv
// Shared types and default constants for the LVDS transmit framer.
package lvds_pkg;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_TRAIN    = 2'd1,
    ST_DATA     = 2'd2
  } state_e;

  localparam int unsigned DATA_WIDTH_DEF   = 10;
  localparam int unsigned RST_CYCLES_DEF   = 8;
  localparam int unsigned TRAIN_CYCLES_DEF = 256;

  // A training length of zero would never let the link come up; treat it as one.
  function automatic int unsigned train_len(input int unsigned n);
    return (n == 32'd0) ? 32'd1 : n;
  endfunction

endpackage

// File: rtl/lvds_tx_framer_if.sv
// User word stream into the framer: valid/ready handshake plus payload.
interface lvds_tx_framer_if
  import lvds_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  s_tvalid;
  logic                  s_tready;

  modport master (output s_tdata, output s_tvalid, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, output s_tready);

endinterface

// File: rtl/lvds_tx_framer.sv
// Word framer ahead of an LVDS serializer: holds the serializer in reset,
// sends the training pattern until the partner is aligned, then streams user words.
module lvds_tx_framer
  import lvds_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned RST_CYCLES   = RST_CYCLES_DEF,
  parameter int unsigned TRAIN_CYCLES = TRAIN_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  train_req,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic [DATA_WIDTH-1:0] idle_word,
  lvds_tx_framer_if.slave       s_axis,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  oserdes_rst,
  output logic                  training,
  output logic                  link_up,
  output logic [15:0]           word_cnt
);

  localparam int unsigned TRAIN_LEN = train_len(TRAIN_CYCLES);
  localparam int unsigned RST_W     = $clog2(RST_CYCLES + 1);
  localparam int unsigned TRN_W     = $clog2(TRAIN_LEN + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TRN_W-1:0] TRN_LAST = TRN_W'(TRAIN_LEN - 1);
  localparam logic [TRN_W-1:0] TRN_MAX  = TRN_W'(TRAIN_LEN);

  state_e                state_q, state_d;
  logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [TRN_W-1:0]      trn_cnt_q, trn_cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  oserdes_rst_q, oserdes_rst_d;
  logic                  training_q, training_d;
  logic                  link_up_q, link_up_d;
  logic [15:0]           word_cnt_q, word_cnt_d;

  logic                  ready_c;
  logic                  xfer_c;

  // Ready only in DATA, dropped the same cycle a retrain or reset is requested.
  assign ready_c         = (state_q == ST_DATA) && !train_req && !reset;
  assign xfer_c          = ready_c && s_axis.s_tvalid;
  assign s_axis.s_tready = ready_c;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the train counter includes the current cycle, hence TRN_LAST.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST_HOLD: if (rst_cnt_q == RST_LAST)                state_d = ST_TRAIN;
      ST_TRAIN:    if ((trn_cnt_q >= TRN_LAST) && !train_req) state_d = ST_DATA;
      ST_DATA:     if (train_req)                             state_d = ST_TRAIN;
      default:                                                state_d = ST_RST_HOLD;
    endcase
  end

  // Output and counter next values, decoded from the state being entered.
  always_comb begin
    rst_cnt_d     = '0;
    trn_cnt_d     = '0;
    tx_data_d     = '0;
    oserdes_rst_d = 1'b0;
    training_d    = 1'b0;
    link_up_d     = 1'b0;
    word_cnt_d    = word_cnt_q + 16'(xfer_c);

    if (state_q == ST_RST_HOLD) begin
      rst_cnt_d = rst_cnt_q + RST_W'(1);
    end
    if (state_q == ST_TRAIN) begin
      trn_cnt_d = (trn_cnt_q == TRN_MAX) ? trn_cnt_q : trn_cnt_q + TRN_W'(1);
    end

    unique case (state_d)
      ST_RST_HOLD: begin
        oserdes_rst_d = 1'b1;
      end
      ST_TRAIN: begin
        training_d = 1'b1;
        tx_data_d  = pattern;
      end
      ST_DATA: begin
        link_up_d = 1'b1;
        tx_data_d = xfer_c ? s_axis.s_tdata : idle_word;
      end
      default: begin
        oserdes_rst_d = 1'b1;
      end
    endcase
  end

  // Registered outputs and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt_q     <= '0;
      trn_cnt_q     <= '0;
      tx_data_q     <= '0;
      oserdes_rst_q <= 1'b1;
      training_q    <= 1'b0;
      link_up_q     <= 1'b0;
      word_cnt_q    <= '0;
    end else begin
      rst_cnt_q     <= rst_cnt_d;
      trn_cnt_q     <= trn_cnt_d;
      tx_data_q     <= tx_data_d;
      oserdes_rst_q <= oserdes_rst_d;
      training_q    <= training_d;
      link_up_q     <= link_up_d;
      word_cnt_q    <= word_cnt_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign oserdes_rst = oserdes_rst_q;
  assign training    = training_q;
  assign link_up     = link_up_q;
  assign word_cnt    = word_cnt_q;

endmodule
